sfx_scheduler: RTL

//   Sound-effect scheduler for the AC'97 output path. Latches one-cycle event

---
 rtl/sfx_scheduler.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: latches event requests, grants them by fixed priority and
// plays one square-wave tone per grant, advancing one sample per AC'97 ready edge.
module sfx_scheduler #(
    parameter logic [19:0] AMPLITUDE   = 20'h08000,
    parameter logic [15:0] HALF0       = 16'd24,
    parameter logic [15:0] HALF1       = 16'd48,
    parameter logic [15:0] HALF2       = 16'd96,
    parameter logic [15:0] HALF3       = 16'd120,
    parameter logic [15:0] DUR0        = 16'd2400,
    parameter logic [15:0] DUR1        = 16'd4800,
    parameter logic [15:0] DUR2        = 16'd9600,
    parameter logic [15:0] DUR3        = 16'd24000,
    parameter logic [15:0] GAP_SAMPLES = 16'd480
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ready,
    input  logic [3:0]  req,
    output logic [19:0] left_out,
    output logic [19:0] right_out,
    output logic        busy,
    output logic [1:0]  active_id
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [19:0] NEG_AMP = ~AMPLITUDE + 20'd1;

    logic [1:0]  state;
    logic [3:0]  pending;
    logic [19:0] sample;
    logic [15:0] phase;
    logic [15:0] dur;
    logic [15:0] gap;
    logic        pol;
    logic        ready_d;

    logic        tick;
    logic        grant;
    logic        preempt;
    logic [1:0]  top_id;
    logic [3:0]  clr;

    function automatic logic [15:0] half_of(input logic [1:0] id);
        case (id)
            2'd0:    half_of = HALF0;
            2'd1:    half_of = HALF1;
            2'd2:    half_of = HALF2;
            default: half_of = HALF3;
        endcase
    endfunction

    function automatic logic [15:0] dur_of(input logic [1:0] id);
        case (id)
            2'd0:    dur_of = DUR0;
            2'd1:    dur_of = DUR1;
            2'd2:    dur_of = DUR2;
            default: dur_of = DUR3;
        endcase
    endfunction

    assign tick = ready & ~ready_d;

    // lowest set index wins
    always_comb begin
        top_id = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (pending[i]) top_id = 2'(i);
    end

    assign grant   = (state == IDLE) && (pending != 4'd0);
    assign preempt = (state == PLAY) && tick && (pending != 4'd0) && (top_id < active_id);
    assign clr     = (grant || preempt) ? (4'd1 << top_id) : 4'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= 4'd0;
            sample    <= 20'd0;
            active_id <= 2'd0;
            phase     <= 16'd0;
            dur       <= 16'd0;
            gap       <= 16'd0;
            pol       <= 1'b0;
            ready_d   <= 1'b0;
        end else begin
            ready_d <= ready;
            // a request arriving in the grant cycle survives the clear
            pending <= (pending & ~clr) | req;
            case (state)
                IDLE: begin
                    if (grant) begin
                        active_id <= top_id;
                        phase     <= 16'd0;
                        pol       <= 1'b1;
                        dur       <= dur_of(top_id);
                        state     <= PLAY;
                    end
                end
                PLAY: begin
                    if (preempt) begin
                        // this tick is already sample 1 of the new tone
                        sample    <= AMPLITUDE;
                        active_id <= top_id;
                        if (half_of(top_id) == 16'd1) begin
                            phase <= 16'd0;
                            pol   <= 1'b0;
                        end else begin
                            phase <= 16'd1;
                            pol   <= 1'b1;
                        end
                        if (dur_of(top_id) == 16'd1) begin
                            dur   <= 16'd0;
                            gap   <= GAP_SAMPLES;
                            state <= GAP;
                        end else begin
                            dur <= dur_of(top_id) - 16'd1;
                        end
                    end else if (tick) begin
                        sample <= pol ? AMPLITUDE : NEG_AMP;
                        if (phase + 16'd1 == half_of(active_id)) begin
                            phase <= 16'd0;
                            pol   <= ~pol;
                        end else begin
                            phase <= phase + 16'd1;
                        end
                        dur <= dur - 16'd1;
                        if (dur == 16'd1) begin
                            gap   <= GAP_SAMPLES;
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        sample <= 20'd0;
                        gap    <= gap - 16'd1;
                        if (gap == 16'd1) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign left_out  = sample;
    assign right_out = sample;
    assign busy      = (state != IDLE);
endmodule
